pipe_result_buffer: RTL and testbench

PIPE_RESULT_BUFFER -- requirements
Module: pipe_result_buffer

---
 rtl/pipe_result_buffer.sv | 146 ++++++++++++++
 tb/tb_pipe_result_buffer.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_result_buffer.sv
// Result buffer for a pipelined adder: tracks valid tokens through the adder and
// stalls it when the FIFO is full. Optional stall counter via PIPE_RESULT_BUFFER_STALL_CNT_EN.
module pipe_result_buffer #(
  parameter int WIDTH = 4,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  output logic                     adder_en,
  input  logic [WIDTH-1:0]         sum_in,
  input  logic                     carry_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_sum,
  output logic                     out_carry,
  output logic [$clog2(DEPTH):0]   level
`ifdef PIPE_RESULT_BUFFER_STALL_CNT_EN
  ,
  output logic [15:0]              stall_cnt
`endif
);

  localparam int LAT = WIDTH + 1;
  localparam int AW  = $clog2(DEPTH);
  localparam int LW  = AW + 1;

  logic [LAT-1:0] vsr_r;
  logic [WIDTH:0] mem_r [DEPTH];
  logic [AW-1:0]  wr_ptr_r;
  logic [AW-1:0]  rd_ptr_r;
  logic [AW-1:0]  rd_next_s;
  logic [LW-1:0]  level_r;
  logic [LW-1:0]  level_pop_s;
  logic           out_valid_r;
  logic           out_carry_r;
  logic [WIDTH-1:0] out_sum_r;
  logic           head_s;
  logic           full_s;
  logic           pop_s;
  logic           push_s;
  logic           adder_en_s;

  // Flow control: the adder advances unless a valid result would have nowhere to go.
  always_comb begin
    head_s      = vsr_r[LAT-1];
    full_s      = (level_r == LW'(DEPTH));
    pop_s       = out_valid_r & out_ready;
    adder_en_s  = rst | ~head_s | ~full_s | pop_s;
    push_s      = head_s & adder_en_s;
    level_pop_s = level_r - LW'(pop_s);
    if (pop_s) begin
      rd_next_s = rd_ptr_r + AW'(1);
    end else begin
      rd_next_s = rd_ptr_r;
    end
  end

  assign adder_en  = adder_en_s;
  assign in_ready  = adder_en_s;
  assign out_valid = out_valid_r;
  assign out_sum   = out_sum_r;
  assign out_carry = out_carry_r;
  assign level     = level_r;

  // Valid-token shadow of the adder pipeline, frozen together with the adder.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vsr_r <= {LAT{1'b0}};
    end else if (adder_en_s) begin
      vsr_r <= {vsr_r[LAT-2:0], in_valid & adder_en_s};
    end else begin
      vsr_r <= vsr_r;
    end
  end

  // Result storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= {(WIDTH+1){1'b0}};
      end
    end else if (push_s) begin
      mem_r[wr_ptr_r] <= {carry_in, sum_in};
    end else begin
      mem_r[wr_ptr_r] <= mem_r[wr_ptr_r];
    end
  end

  // Pointers and occupancy; pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r <= {AW{1'b0}};
      rd_ptr_r <= {AW{1'b0}};
      level_r  <= {LW{1'b0}};
    end else begin
      rd_ptr_r <= rd_next_s;
      if (push_s) begin
        wr_ptr_r <= wr_ptr_r + AW'(1);
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      case ({push_s, pop_s})
        2'b10:   level_r <= level_r + LW'(1);
        2'b01:   level_r <= level_r - LW'(1);
        default: level_r <= level_r;
      endcase
    end
  end

  // Registered head: only entries present before this edge become visible, so a
  // push into an empty FIFO shows up one cycle later (no fall-through).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      out_sum_r   <= {WIDTH{1'b0}};
      out_carry_r <= 1'b0;
    end else begin
      out_valid_r <= (level_pop_s != {LW{1'b0}});
      if (level_pop_s != {LW{1'b0}}) begin
        {out_carry_r, out_sum_r} <= mem_r[rd_next_s];
      end else begin
        {out_carry_r, out_sum_r} <= {out_carry_r, out_sum_r};
      end
    end
  end

`ifdef PIPE_RESULT_BUFFER_STALL_CNT_EN
  logic [15:0] stall_cnt_r;

  assign stall_cnt = stall_cnt_r;

  // Saturating count of cycles where upstream is blocked.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt_r <= 16'h0000;
    end else if (in_valid && !adder_en_s && (stall_cnt_r != 16'hFFFF)) begin
      stall_cnt_r <= stall_cnt_r + 16'h0001;
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_result_buffer.sv
// Directed bench for pipe_result_buffer with a behavioural enable-gated adder pipeline.
module tb_pipe_result_buffer;
  localparam int WIDTH = 4;
  localparam int DEPTH = 4;
  localparam int LAT   = WIDTH + 1;
  localparam int LW    = $clog2(DEPTH) + 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, adder_en, carry_in, out_valid, out_carry;
  logic [WIDTH-1:0] sum_in, out_sum;
  logic [LW-1:0] level;
`ifdef PIPE_RESULT_BUFFER_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  logic [WIDTH-1:0] a = 4'd0;
  logic [WIDTH-1:0] b = 4'd0;
  logic cin = 1'b0;
  logic [WIDTH:0] pipe [LAT];
  logic [WIDTH:0] popped [$];
  int n_cmp = 0;
  int n_bad = 0;
  int acc_cnt = 0;

  // Operand vectors with hand-computed {carry,sum} results.
  logic [WIDTH-1:0] tab_a [12] = '{4'd1, 4'd7, 4'd9, 4'd4, 4'd15, 4'd0, 4'd10, 4'd6, 4'd12, 4'd2, 4'd3, 4'd5};
  logic [WIDTH-1:0] tab_b [12] = '{4'd2, 4'd8, 4'd9, 4'd4, 4'd15, 4'd0, 4'd3,  4'd9, 4'd5,  4'd2, 4'd3, 4'd5};
  logic             tab_c [12] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b1,  1'b0, 1'b0,  1'b1, 1'b0,  1'b0, 1'b0, 1'b0};
  logic [WIDTH:0]   tab_e [9]  = '{5'h03, 5'h10, 5'h12, 5'h09, 5'h1F, 5'h00, 5'h0D, 5'h10, 5'h11};

  always #5 clk = ~clk;

  // External adder: LAT stages, advances only on adder_en, shares rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < LAT; k++) pipe[k] <= '0;
    end else if (adder_en) begin
      pipe[0] <= {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
    end
  end
  assign {carry_in, sum_in} = pipe[LAT-1];

  pipe_result_buffer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .adder_en(adder_en),
    .sum_in(sum_in), .carry_in(carry_in), .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_carry(out_carry), .level(level)
`ifdef PIPE_RESULT_BUFFER_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  task automatic step();
    if (in_valid && in_ready && !rst) acc_cnt++;
    if (out_valid && out_ready) popped.push_back({out_carry, out_sum});
    @(posedge clk);
    #1;
  endtask

  task automatic drive_vec(input int i);
    if (i < 12) begin
      a = tab_a[i];
      b = tab_b[i];
      cin = tab_c[i];
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rst_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rst_level: got %0d want 0", level); end
    n_cmp++; if (out_sum !== 4'd0) begin n_bad++; $display("FAIL rst_out_sum: got %0d want 0", out_sum); end
    n_cmp++; if (out_carry !== 1'b0) begin n_bad++; $display("FAIL rst_out_carry: got %b want 0", out_carry); end
    n_cmp++; if (adder_en !== 1'b1) begin n_bad++; $display("FAIL rst_adder_en: got %b want 1", adder_en); end
    n_cmp++; if (in_ready !== 1'b1) begin n_bad++; $display("FAIL rst_in_ready: got %b want 1", in_ready); end
    rst = 1'b0;
  endtask

  task automatic test_single_add();
    out_ready = 1'b1; popped.delete();
    a = 4'd3; b = 4'd5; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    repeat (5) step();
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_early_valid: got %b want 0 after edge 5", out_valid); end
    n_cmp++; if (level !== 3'd1) begin n_bad++; $display("FAIL single_level_push: got %0d want 1", level); end
    step();
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL single_valid: got %b want 1 after edge 6", out_valid); end
    n_cmp++; if (out_sum !== 4'd8) begin n_bad++; $display("FAIL single_sum: got %0d want 8", out_sum); end
    n_cmp++; if (out_carry !== 1'b0) begin n_bad++; $display("FAIL single_carry: got %b want 0", out_carry); end
    step();
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL single_level_pop: got %0d want 0", level); end
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL single_valid_after_pop: got %b want 0", out_valid); end
    n_cmp++; if (popped.size() !== 1) begin n_bad++; $display("FAIL single_pop_count: got %0d want 1", popped.size()); end
  endtask

  task automatic test_carry();
    int n = 0;
    a = 4'd15; b = 4'd1; cin = 1'b0; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL carry_latency: got %0d edges want 6", n); end
    n_cmp++; if (out_sum !== 4'd0) begin n_bad++; $display("FAIL carry_sum: got %0d want 0", out_sum); end
    n_cmp++; if (out_carry !== 1'b1) begin n_bad++; $display("FAIL carry_carry: got %b want 1", out_carry); end
    step();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0; popped.delete(); acc_cnt = 0;
    drive_vec(0); in_valid = 1'b1;
    repeat (12) begin step(); drive_vec(acc_cnt); end
    in_valid = 1'b0;
    #1;
    n_cmp++; if (acc_cnt !== 9) begin n_bad++; $display("FAIL bp_accepted: got %0d want 9", acc_cnt); end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL bp_level: got %0d want 4", level); end
    n_cmp++; if (adder_en !== 1'b0) begin n_bad++; $display("FAIL bp_adder_en: got %b want 0", adder_en); end
    n_cmp++; if (in_ready !== 1'b0) begin n_bad++; $display("FAIL bp_in_ready: got %b want 0", in_ready); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL bp_out_valid: got %b want 1", out_valid); end
    repeat (2) step();
    n_cmp++; if ({out_carry, out_sum} !== tab_e[0]) begin n_bad++; $display("FAIL bp_head_stable: got %h want %h", {out_carry, out_sum}, tab_e[0]); end
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL bp_level_hold: got %0d want 4", level); end
  endtask

  task automatic test_full_push_pop();
    out_ready = 1'b1;
    #1;
    n_cmp++; if (adder_en !== 1'b1) begin n_bad++; $display("FAIL fpp_adder_en: got %b want 1", adder_en); end
    step();
    out_ready = 1'b0;
    #1;
    n_cmp++; if (level !== 3'd4) begin n_bad++; $display("FAIL fpp_level: got %0d want 4", level); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL fpp_out_valid: got %b want 1", out_valid); end
    n_cmp++; if ({out_carry, out_sum} !== tab_e[1]) begin n_bad++; $display("FAIL fpp_new_head: got %h want %h", {out_carry, out_sum}, tab_e[1]); end
  endtask

  task automatic test_drain();
    int n = 0;
    out_ready = 1'b1;
    while (popped.size() < 9 && n < 40) begin step(); n++; end
    n_cmp++; if (popped.size() !== 9) begin n_bad++; $display("FAIL drain_count: got %0d want 9", popped.size()); end
    for (int i = 0; i < 9; i++) begin
      if (i < popped.size()) begin
        n_cmp++; if (popped[i] !== tab_e[i]) begin n_bad++; $display("FAIL drain_order[%0d]: got %h want %h", i, popped[i], tab_e[i]); end
      end
    end
    repeat (3) step();
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL drain_level: got %0d want 0", level); end
    n_cmp++; if (popped.size() !== 9) begin n_bad++; $display("FAIL drain_extra: got %0d want 9", popped.size()); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    out_ready = 1'b0; popped.delete(); acc_cnt = 0;
    drive_vec(0); in_valid = 1'b1;
    repeat (5) begin step(); drive_vec(acc_cnt); end
    in_valid = 1'b0;
    repeat (2) step();
    n_cmp++; if (level !== 3'd2) begin n_bad++; $display("FAIL rm_level_before: got %0d want 2", level); end
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL rm_valid_before: got %b want 1", out_valid); end
    #1 rst = 1'b1;
    #1;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL rm_out_valid: got %b want 0", out_valid); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rm_level: got %0d want 0", level); end
    n_cmp++; if (out_sum !== 4'd0) begin n_bad++; $display("FAIL rm_out_sum: got %0d want 0", out_sum); end
    n_cmp++; if (adder_en !== 1'b1) begin n_bad++; $display("FAIL rm_adder_en: got %b want 1", adder_en); end
    step();
    rst = 1'b0;
    out_ready = 1'b1;
    repeat (15) step();
    n_cmp++; if (popped.size() !== 0) begin n_bad++; $display("FAIL rm_stale: got %0d results want 0", popped.size()); end
    n_cmp++; if (level !== 3'd0) begin n_bad++; $display("FAIL rm_level_after: got %0d want 0", level); end
    a = 4'd2; b = 4'd3; cin = 1'b1; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    while (!out_valid && n < 20) begin step(); n++; end
    n_cmp++; if (n !== 6) begin n_bad++; $display("FAIL rm_fresh_latency: got %0d edges want 6", n); end
    n_cmp++; if ({out_carry, out_sum} !== 5'h06) begin n_bad++; $display("FAIL rm_fresh_result: got %h want 06", {out_carry, out_sum}); end
    step();
    n_cmp++; if (popped.size() !== 1) begin n_bad++; $display("FAIL rm_fresh_count: got %0d want 1", popped.size()); end
  endtask

`ifdef PIPE_RESULT_BUFFER_STALL_CNT_EN
  task automatic test_stall_cnt();
    n_cmp++; if (stall_cnt !== 16'd0) begin n_bad++; $display("FAIL stall_start: got %0d want 0", stall_cnt); end
    out_ready = 1'b0;
    a = 4'd1; b = 4'd1; cin = 1'b0; in_valid = 1'b1;
    repeat (19) step();
    in_valid = 1'b0;
    #1;
    n_cmp++; if (stall_cnt !== 16'd10) begin n_bad++; $display("FAIL stall_count: got %0d want 10", stall_cnt); end
    step();
    n_cmp++; if (stall_cnt !== 16'd10) begin n_bad++; $display("FAIL stall_hold: got %0d want 10", stall_cnt); end
  endtask
`endif

  initial begin
    test_reset();
    test_single_add();
    test_carry();
    test_backpressure();
    test_full_push_pop();
    test_drain();
    test_reset_mid();
`ifdef PIPE_RESULT_BUFFER_STALL_CNT_EN
    test_stall_cnt();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
